// File: rtl/async_hs_sink.sv
`default_nettype none
// ============================================================================
//  Module      : async_hs_sink
//  Description : Clocked terminating end of a 4-phase bundled-data channel.
//                Synchronises the incoming request, captures the bundled
//                data word into a small FIFO, returns the acknowledge with
//                return-to-zero sequencing, and presents captured words to
//                synchronous logic through a valid/ready read port.
//  Revision    : 1.0  initial release
// ----------------------------------------------------------------------------
//  Parameters
//    DATA_W      width of the bundled data word
//    DEPTH       FIFO entries (power of two, >= 2)
//    SYNC_STAGES flops in the req_in synchroniser (>= 2)
//  Ports
//    clk       in   sole clock
//    rst       in   asynchronous active-low reset
//    req_in    in   4-phase request, asynchronous to clk
//    data_in   in   bundled data, stable while req_in is high
//    ack_out   out  4-phase acknowledge (registered)
//    rd_valid  out  FIFO non-empty
//    rd_ready  in   consumer accepts the head word
//    rd_data   out  head word (valid while rd_valid is high)
//    level     out  current FIFO occupancy
//    xfer_cnt  out  16-bit completed-request counter, present only when
//                   ASYNC_HS_SINK_STATS_EN is defined
// ============================================================================
module async_hs_sink #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_in,
    input  logic [DATA_W-1:0]          data_in,
    output logic                       ack_out,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef ASYNC_HS_SINK_STATS_EN
    ,
    output logic [15:0]                xfer_cnt
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    ack_q, ack_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [DATA_W-1:0]       mem_q [DEPTH];

    logic                    req_s;
    logic                    full;
    logic                    wr_en;
    logic                    rd_en;

    // Only req_in is synchronised; data_in is covered by the bundling
    // constraint and is sampled directly on the write edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Fullness is taken from the pre-edge level, so a pop on the same edge
    // never opens room for a write; that write lands one edge later.
    assign full  = (level_q == LVL_W'(DEPTH));
    assign rd_en = (level_q != '0) && rd_ready;

    always_comb begin
        state_d = state_q;
        ack_d   = ack_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_s && !full) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    wr_en   = 1'b1;
                end
            end
            S_ACK: begin
                if (!req_s) begin
                    state_d = S_IDLE;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            ack_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            state_q  <= state_d;
            ack_q    <= ack_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; entries are only observable once written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign ack_out  = ack_q;
    assign rd_valid = (level_q != '0);
    assign rd_data  = mem_q[rd_ptr_q];
    assign level    = level_q;

`ifdef ASYNC_HS_SINK_STATS_EN
    logic [15:0] xfer_cnt_q;

    // Counts accepted requests (every IDLE-to-ACK step); wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xfer_cnt_q <= '0;
        end else if (wr_en) begin
            xfer_cnt_q <= xfer_cnt_q + 16'd1;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_async_hs_sink.sv
`default_nettype none
// ============================================================================
//  Module      : tb_async_hs_sink
//  Description : Directed self-checking bench for async_hs_sink with a word
//                scoreboard filled at request time and drained on each pop.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_async_hs_sink;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;
    localparam int LVL_W  = $clog2(DEPTH + 1);

    logic              clk;
    logic              rst;
    logic              req_in;
    logic [DATA_W-1:0] data_in;
    logic              ack_out;
    logic              rd_valid;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic [LVL_W-1:0]  level;
`ifdef ASYNC_HS_SINK_STATS_EN
    logic [15:0]       xfer_cnt;
`endif

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] sb_q[$];
    logic wrap_phase = 1'b0;

    async_hs_sink #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .SYNC_STAGES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req_in   (req_in),
        .data_in  (data_in),
        .ack_out  (ack_out),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .rd_data  (rd_data),
        .level    (level)
`ifdef ASYNC_HS_SINK_STATS_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic val, input string tag, output int n);
        n = 0;
        while (ack_out !== val && n < 40) begin
            tick();
            n++;
        end
        check(tag, {31'd0, ack_out}, {31'd0, val});
    endtask

    task automatic hs(input logic [DATA_W-1:0] d);
        int n;
        req_in  = 1'b1;
        data_in = d;
        sb_q.push_back(d);
        wait_ack(1'b1, "hs_ack_rise", n);
        req_in = 1'b0;
        wait_ack(1'b0, "hs_ack_fall", n);
    endtask

    task automatic drain();
        int n;
        n = 0;
        rd_ready = 1'b1;
        while (level != '0 && n < 50) begin
            tick();
            n++;
        end
        rd_ready = 1'b0;
        check("drain_level", 32'(level), 32'd0);
        check("drain_sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    // Consumer-side monitor: every accepted word must match the oldest
    // outstanding expected word.
    always @(negedge clk) begin
        if (rst === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check("rd_data", 32'(rd_data), 32'(sb_q.pop_front()));
            end
        end
        if (wrap_phase) begin
            check("wrap_level_le2", {31'd0, (level <= LVL_W'(2))}, 32'd1);
        end
    end

    initial begin
        int n;
        rst      = 1'b0;
        req_in   = 1'b0;
        data_in  = '0;
        rd_ready = 1'b0;

        // Reset state
        #12;
        check("rst_ack", {31'd0, ack_out}, 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Single transfer with exact latency
        req_in  = 1'b1;
        data_in = 8'hA5;
        sb_q.push_back(8'hA5);
        wait_ack(1'b1, "single_ack_rise", n);
        check("single_rise_lat", 32'(n), 32'd3);
        check("single_valid", {31'd0, rd_valid}, 32'd1);
        check("single_data", 32'(rd_data), 32'hA5);
        check("single_level", 32'(level), 32'd1);
        req_in = 1'b0;
        wait_ack(1'b0, "single_ack_fall", n);
        check("single_fall_lat", 32'(n), 32'd3);
        drain();

        // Fill, stall, and full-with-simultaneous-pop
        for (int i = 1; i <= 4; i++) hs(8'(i));
        check("fill_level", 32'(level), 32'd4);
        req_in  = 1'b1;
        data_in = 8'h05;
        sb_q.push_back(8'h05);
        repeat (10) tick();
        check("stall_ack", {31'd0, ack_out}, 32'd0);
        check("stall_level", 32'(level), 32'd4);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("pop_full_level", 32'(level), 32'd3);
        check("pop_full_no_ack", {31'd0, ack_out}, 32'd0);
        tick();
        check("late_write_ack", {31'd0, ack_out}, 32'd1);
        check("late_write_level", 32'(level), 32'd4);
        req_in = 1'b0;
        wait_ack(1'b0, "stall_ack_fall", n);
        drain();

        // Order and pointer wrap with a consumer always ready
        rd_ready   = 1'b1;
        wrap_phase = 1'b1;
        for (int i = 0; i < 10; i++) hs(8'h10 + 8'(i));
        repeat (3) tick();
        wrap_phase = 1'b0;
        rd_ready   = 1'b0;
        check("wrap_sb_empty", 32'(sb_q.size()), 32'd0);
        check("wrap_level", 32'(level), 32'd0);

        // Reset mid-handshake while in ACK with two words stored
        hs(8'h21);
        req_in  = 1'b1;
        data_in = 8'h33;
        sb_q.push_back(8'h33);
        wait_ack(1'b1, "mid_ack_rise", n);
        check("mid_level", 32'(level), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_ack", {31'd0, ack_out}, 32'd0);
        check("mid_rst_level", 32'(level), 32'd0);
        check("mid_rst_valid", {31'd0, rd_valid}, 32'd0);
        sb_q.delete();
        sb_q.push_back(8'h33);
        tick();
        tick();
        rst = 1'b1;
        wait_ack(1'b1, "recap_ack_rise", n);
        check("recap_lat", 32'(n), 32'd3);
        check("recap_level", 32'(level), 32'd1);
        req_in = 1'b0;
        wait_ack(1'b0, "recap_ack_fall", n);
        drain();

`ifdef ASYNC_HS_SINK_STATS_EN
        force dut.xfer_cnt_q = 16'hFFFF;
        #1;
        release dut.xfer_cnt_q;
        hs(8'h77);
        check("xfer_cnt_wrap", 32'(xfer_cnt), 32'd0);
        drain();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
